mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port memory bus (16-bit data, 9-bit address, `mem_cmd` encoding) between the CPU and a second master such as a program loader or DMA engine. It sits between the requesters and the existing bus decode (RAM at `addr[8]==0`, LED/switch I/O above). Requesters use a request/acknowledge handshake. The arbiter accounts for the one-cycle read latency of the synchronous RAM, so each requester sees a registered `ack` pulse and valid `rdata` in the same cycle.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 13 +
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions for the CPU, the arbiter and the bus top.
// Command encoding, default widths and the arbiter state encoding.
package mem_bus_pkg;

    localparam int MEM_DW = 16;
    localparam int MEM_AW = 9;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } arb_state_t;

    // 2'b11 is not a command; it decodes to no request.
    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that did not win last time.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |req;
    assign grant_idx   = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port memory bus with a one-cycle
// synchronous-read latency; each access is IDLE -> ACCESS -> RESP.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DW = MEM_DW,
    parameter int AW = MEM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    p0_cmd,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic [1:0]    p1_cmd,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    arb_state_t    state, state_n;
    logic [1:0]    req;
    logic          grant_valid;
    logic          grant_idx;
    logic          last_grant;
    logic          load;
    logic          rd_pend;
    logic [DW-1:0] p0_rdata_q;
    logic [DW-1:0] p1_rdata_q;

    assign req = {is_req(p1_cmd), is_req(p0_cmd)};

    rr_pick2 u_pick (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: state_n = S_RESP;
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_cmd    <= MNONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            rd_pend    <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            p0_ack  <= 1'b0;
            p1_ack  <= 1'b0;
            mem_cmd <= MNONE;
            if (load) begin
                mem_cmd    <= grant_idx ? p1_cmd   : p0_cmd;
                mem_addr   <= grant_idx ? p1_addr  : p0_addr;
                mem_wdata  <= grant_idx ? p1_wdata : p0_wdata;
                owner      <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == S_ACCESS) begin
                rd_pend <= (mem_cmd == MREAD);
                p0_ack  <= ~owner;
                p1_ack  <= owner;
            end
            // Read data is live on the bus only during RESP; keep a copy.
            if (state == S_RESP && rd_pend) begin
                if (owner) p1_rdata_q <= mem_rdata;
                else       p0_rdata_q <= mem_rdata;
            end
        end
    end

    assign p0_rdata = (p0_ack && rd_pend) ? mem_rdata : p0_rdata_q;
    assign p1_rdata = (p1_ack && rd_pend) ? mem_rdata : p1_rdata_q;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model
// on the bus side.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  p0_cmd, p1_cmd;
    logic [8:0]  p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy, owner;

    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] ram [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_cmd    (p0_cmd),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_rdata  (p0_rdata),
        .p1_cmd    (p1_cmd),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_rdata  (p1_rdata),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    // RAM below addr[8]; read data appears one cycle after the address.
    always @(posedge clk) begin
        if (ld_en)
            ram[ld_addr] <= ld_data;
        else if (mem_cmd == 2'b10 && !mem_addr[8])
            ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        tick();
        ld_en   = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        p0_cmd   = 2'b00; p0_addr = '0; p0_wdata = '0;
        p1_cmd   = 2'b00; p1_addr = '0; p1_wdata = '0;
        ld_en    = 1'b0;  ld_addr = '0; ld_data  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_cmd", mem_cmd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_p0_ack", p0_ack, 0);
        check("rst_p1_ack", p1_ack, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        tick();
        reset = 1'b1;

        preload(8'h05, 16'h1234);
        preload(8'h01, 16'h1111);
        preload(8'h02, 16'h2222);
        preload(8'h20, 16'hAAAA);
        tick();

        // single read by port 0
        p0_cmd = 2'b01; p0_addr = 9'h005;
        @(negedge clk);
        check("rd_c0_busy", busy, 0);
        tick();
        @(negedge clk);
        check("rd_c1_cmd", mem_cmd, 2'b01);
        check("rd_c1_addr", mem_addr, 9'h005);
        check("rd_c1_busy", busy, 1);
        tick();
        @(negedge clk);
        check("rd_c2_ack0", p0_ack, 1);
        check("rd_c2_rdata0", p0_rdata, 16'h1234);
        check("rd_c2_ack1", p1_ack, 0);
        check("rd_c2_cmd", mem_cmd, 0);
        tick();
        p0_cmd = 2'b00;
        @(negedge clk);
        check("rd_c3_ack0", p0_ack, 0);
        check("rd_c3_hold", p0_rdata, 16'h1234);
        check("rd_c3_busy", busy, 0);
        tick();

        // port 1 write then read back
        p1_cmd = 2'b10; p1_addr = 9'h010; p1_wdata = 16'hBEEF;
        tick();
        @(negedge clk);
        check("wr_c1_cmd", mem_cmd, 2'b10);
        check("wr_c1_addr", mem_addr, 9'h010);
        check("wr_c1_wdata", mem_wdata, 16'hBEEF);
        tick();
        @(negedge clk);
        check("wr_c2_cmd", mem_cmd, 0);
        check("wr_c2_ack1", p1_ack, 1);
        check("wr_c2_ack0", p0_ack, 0);
        check("wr_c2_rdata1", p1_rdata, 0);
        check("wr_c2_owner", owner, 1);
        tick();
        p1_cmd = 2'b00;
        tick();
        p1_cmd = 2'b01; p1_addr = 9'h010;
        tick();
        tick();
        @(negedge clk);
        check("rb_c2_ack1", p1_ack, 1);
        check("rb_c2_rdata1", p1_rdata, 16'hBEEF);
        tick();
        p1_cmd = 2'b00;
        tick();

        // simultaneous requests right after reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        p0_cmd = 2'b01; p0_addr = 9'h001;
        p1_cmd = 2'b01; p1_addr = 9'h002;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) p0_cmd = 2'b00;
            if (c == 6) p1_cmd = 2'b00;
            @(negedge clk);
            check($sformatf("tie_ack0_c%0d", c), p0_ack, c == 2);
            check($sformatf("tie_ack1_c%0d", c), p1_ack, c == 5);
            if (c == 2) begin
                check("tie_owner_c2", owner, 0);
                check("tie_rdata0", p0_rdata, 16'h1111);
            end
            if (c == 5) begin
                check("tie_owner_c5", owner, 1);
                check("tie_rdata1", p1_rdata, 16'h2222);
            end
            tick();
        end

        // continuous contention: strict alternation
        p0_cmd = 2'b01; p0_addr = 9'h001;
        p1_cmd = 2'b01; p1_addr = 9'h002;
        for (int c = 0; c < 13; c++) begin
            if (c == 12) begin
                p0_cmd = 2'b00;
                p1_cmd = 2'b00;
            end
            @(negedge clk);
            check($sformatf("rr_ack0_c%0d", c), p0_ack,
                  (c % 3 == 2) && ((c / 3) % 2 == 0));
            check($sformatf("rr_ack1_c%0d", c), p1_ack,
                  (c % 3 == 2) && ((c / 3) % 2 == 1));
            check($sformatf("rr_excl_c%0d", c), p0_ack & p1_ack, 0);
            tick();
        end

        // reset while a write is on the bus
        p0_cmd = 2'b10; p0_addr = 9'h020; p0_wdata = 16'h5555;
        @(negedge clk);
        check("rst_wr_c0_busy", busy, 0);
        tick();
        check("rst_wr_c1_cmd", mem_cmd, 2'b10);
        #2;
        reset = 1'b0;
        #1;
        check("rst_wr_cmd_drop", mem_cmd, 0);
        check("rst_wr_busy", busy, 0);
        check("rst_wr_ack0", p0_ack, 0);
        p0_cmd = 2'b00;
        tick();
        @(negedge clk);
        check("rst_wr_noack", p0_ack, 0);
        check("rst_wr_ram", ram[8'h20], 16'hAAAA);
        tick();
        reset = 1'b1;
        p0_cmd = 2'b01; p0_addr = 9'h020;
        p1_cmd = 2'b01; p1_addr = 9'h005;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) p0_cmd = 2'b00;
            if (c == 6) p1_cmd = 2'b00;
            @(negedge clk);
            if (c == 2) begin
                check("post_ack0", p0_ack, 1);
                check("post_ack1", p1_ack, 0);
                check("post_owner", owner, 0);
                check("post_rdata0", p0_rdata, 16'hAAAA);
            end
            if (c == 5) begin
                check("post_ack1_c5", p1_ack, 1);
                check("post_rdata1", p1_rdata, 16'h1234);
            end
            tick();
        end

        // 2'b11 is not a request
        p0_cmd = 2'b11; p0_addr = 9'h005;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("ill_busy_c%0d", c), busy, 0);
            check($sformatf("ill_cmd_c%0d", c), mem_cmd, 0);
            check($sformatf("ill_ack_c%0d", c), p0_ack, 0);
            tick();
        end
        p0_cmd = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
